// File: rtl/bcd_counter_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bcd_counter_sequencer
//
// Purpose:
//   Controller for a cascade of DIGITS 74162-style synchronous BCD decade
//   counters. It loads a validated BCD preset, runs the cascade up to the
//   all-9s terminal count and then either holds (one-shot) or reloads the
//   preset with no dead cycle (auto-reload). Start / pause (Stop) / resume
//   (Start) / Abort control is provided. The only feedback from the counters
//   is the ripple-carry output of the most-significant stage.
//
// Optional feature (compile-time macro BCD_COUNTER_SEQUENCER_CYCLES_EN):
//   defined   -> o_cycles is an 8-bit saturating count of terminal-count edges,
//                cleared on reset and on every accepted Start from IDLE/DONE.
//   undefined -> no counter register is built and o_cycles is tied to 0.
//
// Parameters:
//   DIGITS      number of cascaded decade counters (preset is 4*DIGITS bits)
//   DELAY_RISE  rising-edge delay on every output, in clk cycles
//   DELAY_FALL  falling-edge delay on every output, in clk cycles
//
// Ports:
//   i_clk            system clock, all state changes on the rising edge
//   i_clear_bar      asynchronous active-low reset of the controller only
//   i_start          begin from IDLE/DONE, resume from HALT
//   i_stop           pause while running
//   i_abort          cancel and clear the counters
//   i_auto_reload    1 = reload at terminal count, 0 = one-shot
//   i_preset         BCD start value, digit 0 in bits [3:0]
//   i_rco_chain      RCO of the most-significant counter
//   o_cnt_clear_bar  to every counter's Clear_bar
//   o_cnt_load_bar   to every counter's Load_bar
//   o_cnt_ent        to the least-significant counter's ENT
//   o_cnt_enp        to every counter's ENP
//   o_cnt_d          preset latched at Start, to the counters' D inputs
//   o_busy           high in LOAD, RUN and HALT
//   o_done           high in DONE
//   o_error          sticky invalid-preset flag
//   o_cycles         completed-interval count (see optional feature)
// -----------------------------------------------------------------------------
module bcd_counter_sequencer #(
    parameter int DIGITS     = 2,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                  i_clk,
    input  logic                  i_clear_bar,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_abort,
    input  logic                  i_auto_reload,
    input  logic [4*DIGITS-1:0]   i_preset,
    input  logic                  i_rco_chain,
    output logic                  o_cnt_clear_bar,
    output logic                  o_cnt_load_bar,
    output logic                  o_cnt_ent,
    output logic                  o_cnt_enp,
    output logic [4*DIGITS-1:0]   o_cnt_d,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [7:0]            o_cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_CLR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Packed output vector: {clear_bar, load_bar, ent, enp, cnt_d, busy, done, error, cycles}
    localparam int OW = 4*DIGITS + 15;
    localparam logic [OW-1:0] RST_VEC = {2'b11, {(OW-2){1'b0}}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [4*DIGITS-1:0]    r_cnt_d;
    logic                   r_error;
    logic [7:0]             w_cycles;

    logic [DIGITS-1:0]      w_digit_bad;
    logic                   w_preset_ok;
    logic                   w_idle_like;
    logic                   w_start_ok;
    logic                   w_start_bad;
    logic                   w_terminal;

    logic                   w_cnt_clear_bar;
    logic                   w_cnt_load_bar;
    logic                   w_cnt_ent;
    logic                   w_cnt_enp;
    logic                   w_busy;
    logic                   w_done;

    logic [OW-1:0]          w_out_raw;
    logic [OW-1:0]          w_out;

    genvar gi;

    // ------------------------------------------------------------------
    // Preset validation: every nibble must be a legal BCD digit.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
            assign w_digit_bad[gi] = (i_preset[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_preset_ok = ~|w_digit_bad;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_ok  = w_idle_like && i_start && w_preset_ok;
    assign w_start_bad = w_idle_like && i_start && !w_preset_ok;

    // Terminal count is only honoured while running, and Abort outranks it.
    assign w_terminal  = (r_state == S_RUN) && i_rco_chain && !i_abort;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_clear_bar) begin
        if (!i_clear_bar) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_next = S_LOAD;
                end else if (w_start_bad) begin
                    w_state_next = S_CLR;
                end
            end
            S_LOAD: begin
                w_state_next = i_abort ? S_CLR : S_RUN;
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_next = S_CLR;
                end else if (w_terminal) begin
                    w_state_next = i_auto_reload ? S_RUN : S_DONE;
                end else if (i_stop) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (i_abort) begin
                    w_state_next = S_CLR;
                end else if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_CLR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (counter control strobes and status)
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_clear_bar = 1'b1;
        w_cnt_load_bar  = 1'b1;
        w_cnt_ent       = 1'b0;
        w_cnt_enp       = 1'b0;
        w_busy          = 1'b0;
        w_done          = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_cnt_load_bar = 1'b0;
                w_cnt_ent      = 1'b1;
                w_busy         = 1'b1;
            end
            S_RUN: begin
                w_cnt_ent = 1'b1;
                w_busy    = 1'b1;
                // One-shot: drop ENP at terminal count so the cascade holds all-9s.
                w_cnt_enp = !(i_rco_chain && !i_auto_reload);
                // Auto-reload: load overrides count inside the counters, so the
                // terminal edge itself reloads the preset with no idle cycle.
                w_cnt_load_bar = !(i_rco_chain && i_auto_reload);
            end
            S_HALT: begin
                w_cnt_ent = 1'b1;
                w_busy    = 1'b1;
            end
            S_CLR: begin
                w_cnt_clear_bar = 1'b0;
            end
            S_DONE: begin
                w_cnt_ent = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Preset latch and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_clear_bar) begin
        if (!i_clear_bar) begin
            r_cnt_d <= '0;
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_cnt_d <= i_preset;
            r_error <= 1'b0;
        end else if (w_start_bad) begin
            r_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completed-interval counter
    // ------------------------------------------------------------------
`ifdef BCD_COUNTER_SEQUENCER_CYCLES_EN
    logic [7:0] r_cycles;

    always_ff @(posedge i_clk or negedge i_clear_bar) begin
        if (!i_clear_bar) begin
            r_cycles <= '0;
        end else if (w_start_ok) begin
            r_cycles <= '0;
        end else if (w_terminal && (r_cycles != 8'hFF)) begin
            r_cycles <= r_cycles + 8'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Output stage with optional per-edge delays
    // ------------------------------------------------------------------
    assign w_out_raw = {w_cnt_clear_bar, w_cnt_load_bar, w_cnt_ent, w_cnt_enp,
                        r_cnt_d, w_busy, w_done, r_error, w_cycles};

    generate
        if ((DELAY_RISE == 0) && (DELAY_FALL == 0)) begin : g_no_delay
            assign w_out = w_out_raw;
        end else begin : g_delay
            localparam int DMAX = (DELAY_RISE > DELAY_FALL) ? DELAY_RISE : DELAY_FALL;

            // w_tap[k] is the raw output vector delayed by k cycles.
            logic [DMAX:0][OW-1:0] w_tap;
            logic [OW-1:0]         r_last;

            assign w_tap[0] = w_out_raw;

            for (gi = 0; gi < DMAX; gi++) begin : g_stage
                logic [OW-1:0] r_stage;
                always_ff @(posedge i_clk or negedge i_clear_bar) begin
                    if (!i_clear_bar) begin
                        r_stage <= RST_VEC;
                    end else begin
                        r_stage <= w_tap[gi];
                    end
                end
                assign w_tap[gi+1] = r_stage;
            end

            // A bit currently low rises when the rise-delayed tap goes high;
            // a bit currently high falls when the fall-delayed tap goes low.
            assign w_out = (r_last & w_tap[DELAY_FALL]) | (~r_last & w_tap[DELAY_RISE]);

            always_ff @(posedge i_clk or negedge i_clear_bar) begin
                if (!i_clear_bar) begin
                    r_last <= RST_VEC;
                end else begin
                    r_last <= w_out;
                end
            end
        end
    endgenerate

    assign o_cnt_clear_bar = w_out[OW-1];
    assign o_cnt_load_bar  = w_out[OW-2];
    assign o_cnt_ent       = w_out[OW-3];
    assign o_cnt_enp       = w_out[OW-4];
    assign o_cnt_d         = w_out[11 +: 4*DIGITS];
    assign o_busy          = w_out[10];
    assign o_done          = w_out[9];
    assign o_error         = w_out[8];
    assign o_cycles        = w_out[7:0];

endmodule

// File: tb/tb_bcd_counter_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bcd_counter_sequencer
//
// Drives the sequencer against a behavioural two-digit 74162 cascade. Each
// scenario task pushes the expected {counter value, busy, done, error, cycles}
// into a scoreboard queue as it drives a cycle's stimulus, then pops and
// compares once the edge has been taken (outputs sampled on the falling edge).
// -----------------------------------------------------------------------------
module tb_bcd_counter_sequencer;

    logic       clk = 1'b0;
    logic       clear_bar;
    logic       start;
    logic       stop;
    logic       abort;
    logic       auto_reload;
    logic [7:0] preset;
    logic       rco_chain;

    logic       o_cnt_clear_bar;
    logic       o_cnt_load_bar;
    logic       o_cnt_ent;
    logic       o_cnt_enp;
    logic [7:0] o_cnt_d;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_cycles;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] sb[$];

    // Behavioural cascade of two 74162 counters, arbitrary power-up contents.
    logic [7:0] m_cnt = 8'h55;

    always #5 clk = ~clk;

    bcd_counter_sequencer #(
        .DIGITS     (2),
        .DELAY_RISE (0),
        .DELAY_FALL (0)
    ) dut (
        .i_clk           (clk),
        .i_clear_bar     (clear_bar),
        .i_start         (start),
        .i_stop          (stop),
        .i_abort         (abort),
        .i_auto_reload   (auto_reload),
        .i_preset        (preset),
        .i_rco_chain     (rco_chain),
        .o_cnt_clear_bar (o_cnt_clear_bar),
        .o_cnt_load_bar  (o_cnt_load_bar),
        .o_cnt_ent       (o_cnt_ent),
        .o_cnt_enp       (o_cnt_enp),
        .o_cnt_d         (o_cnt_d),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_cycles        (o_cycles)
    );

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        d0 = v[3:0];
        d1 = v[7:4];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            d1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d1, d0};
    endfunction

    always @(posedge clk) begin
        if (!o_cnt_clear_bar)
            m_cnt <= 8'h00;
        else if (!o_cnt_load_bar)
            m_cnt <= o_cnt_d;
        else if (o_cnt_ent && o_cnt_enp)
            m_cnt <= bcd_inc(m_cnt);
    end

    // MS-stage RCO: ENT ripples through stage 0 only when digit 0 is 9.
    assign rco_chain = o_cnt_ent && (m_cnt == 8'h99);

    function automatic logic [18:0] mk(input logic [7:0] cnt, input logic b,
                                       input logic d, input logic e, input logic [7:0] c);
`ifdef BCD_COUNTER_SEQUENCER_CYCLES_EN
        return {cnt, b, d, e, c};
`else
        return {cnt, b, d, e, 8'h00};
`endif
    endfunction

    function automatic logic [18:0] obs();
        return {m_cnt, o_busy, o_done, o_error, o_cycles};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [22:0] got;
        repeat (3) step();
        got = {o_cnt_clear_bar, o_cnt_load_bar, o_cnt_ent, o_cnt_enp, o_cnt_d,
               o_busy, o_done, o_error, o_cycles};
        n_checks++;
        if (got !== {4'b1100, 8'h00, 3'b000, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required %h", got, {4'b1100, 8'h00, 3'b000, 8'h00});
        end
        n_checks++;
        if (m_cnt !== 8'h55) begin
            n_errors++;
            $display("FAIL reset_counters_hold: got %h required 55", m_cnt);
        end
        clear_bar = 1'b1;
        $display("test_reset: done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_one_shot();
        logic [18:0] exp_v [8];
        logic [18:0] e;
        logic [18:0] got;
        exp_v[0] = mk(m_cnt, 1, 0, 0, 8'd0);
        exp_v[1] = mk(8'h95, 1, 0, 0, 8'd0);
        exp_v[2] = mk(8'h96, 1, 0, 0, 8'd0);
        exp_v[3] = mk(8'h97, 1, 0, 0, 8'd0);
        exp_v[4] = mk(8'h98, 1, 0, 0, 8'd0);
        exp_v[5] = mk(8'h99, 1, 0, 0, 8'd0);
        exp_v[6] = mk(8'h99, 0, 1, 0, 8'd1);
        exp_v[7] = mk(8'h99, 0, 1, 0, 8'd1);
        preset = 8'h95;
        auto_reload = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            sb.push_back(exp_v[i]);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL one_shot[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            if (i == 0) begin
                n_checks++;
                if ({o_cnt_load_bar, o_cnt_ent, o_cnt_enp, o_cnt_d} !== {3'b010, 8'h95}) begin
                    n_errors++;
                    $display("FAIL one_shot_load {ld_b,ent,enp,d}: got %h required %h",
                             {o_cnt_load_bar, o_cnt_ent, o_cnt_enp, o_cnt_d}, {3'b010, 8'h95});
                end
            end
            if (i == 5) begin
                n_checks++;
                if ({o_cnt_ent, o_cnt_enp, o_cnt_load_bar} !== 3'b101) begin
                    n_errors++;
                    $display("FAIL one_shot_terminal {ent,enp,ld_b}: got %b required 101",
                             {o_cnt_ent, o_cnt_enp, o_cnt_load_bar});
                end
            end
            $display("one_shot[%0d]: cnt=%h busy=%b done=%b cyc=%0d", i, m_cnt, o_busy, o_done, o_cycles);
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_bad_preset();
        logic [18:0] exp_v [6];
        logic [18:0] e;
        logic [18:0] got;
        logic        clr_exp [6];
        exp_v[0] = mk(8'h99, 0, 0, 1, 8'd1);  clr_exp[0] = 1'b0;
        exp_v[1] = mk(8'h00, 0, 0, 1, 8'd1);  clr_exp[1] = 1'b1;
        exp_v[2] = mk(8'h00, 1, 0, 0, 8'd0);  clr_exp[2] = 1'b1;
        exp_v[3] = mk(8'h10, 1, 0, 0, 8'd0);  clr_exp[3] = 1'b1;
        exp_v[4] = mk(8'h11, 0, 0, 0, 8'd0);  clr_exp[4] = 1'b0;
        exp_v[5] = mk(8'h00, 0, 0, 0, 8'd0);  clr_exp[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            preset = (i < 2) ? 8'h3A : 8'h10;
            start  = (i == 0) || (i == 2);
            abort  = (i == 4);
            sb.push_back(exp_v[i]);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL bad_preset[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            n_checks++;
            if (o_cnt_clear_bar !== clr_exp[i]) begin
                n_errors++;
                $display("FAIL bad_preset_clear[%0d]: got %b required %b", i, o_cnt_clear_bar, clr_exp[i]);
            end
            $display("bad_preset[%0d]: cnt=%h err=%b clr_b=%b busy=%b", i, m_cnt, o_error, o_cnt_clear_bar, o_busy);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_auto_reload();
        logic [18:0] exp_v [8];
        logic [18:0] e;
        logic [18:0] got;
        exp_v[0] = mk(8'h00, 1, 0, 0, 8'd0);
        exp_v[1] = mk(8'h97, 1, 0, 0, 8'd0);
        exp_v[2] = mk(8'h98, 1, 0, 0, 8'd0);
        exp_v[3] = mk(8'h99, 1, 0, 0, 8'd0);
        exp_v[4] = mk(8'h97, 1, 0, 0, 8'd1);
        exp_v[5] = mk(8'h98, 1, 0, 0, 8'd1);
        exp_v[6] = mk(8'h99, 1, 0, 0, 8'd1);
        exp_v[7] = mk(8'h97, 1, 0, 0, 8'd2);
        preset = 8'h97;
        auto_reload = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            sb.push_back(exp_v[i]);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL auto_reload[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            if (i == 3) begin
                n_checks++;
                if ({o_cnt_load_bar, o_cnt_ent, o_cnt_enp} !== 3'b011) begin
                    n_errors++;
                    $display("FAIL auto_reload_terminal {ld_b,ent,enp}: got %b required 011",
                             {o_cnt_load_bar, o_cnt_ent, o_cnt_enp});
                end
            end
            $display("auto_reload[%0d]: cnt=%h cyc=%0d ld_b=%b", i, m_cnt, o_cycles, o_cnt_load_bar);
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Continues the auto-reload run: terminal count with Stop, then with Abort.
    task automatic test_priority();
        logic [18:0] exp_v [7];
        logic [18:0] e;
        logic [18:0] got;
        exp_v[0] = mk(8'h98, 1, 0, 0, 8'd2);
        exp_v[1] = mk(8'h99, 1, 0, 0, 8'd2);
        exp_v[2] = mk(8'h97, 1, 0, 0, 8'd3);
        exp_v[3] = mk(8'h98, 1, 0, 0, 8'd3);
        exp_v[4] = mk(8'h99, 1, 0, 0, 8'd3);
        exp_v[5] = mk(8'h97, 0, 0, 0, 8'd3);
        exp_v[6] = mk(8'h00, 0, 0, 0, 8'd3);
        for (int i = 0; i < 7; i++) begin
            stop  = (i == 2) || (i == 5);
            abort = (i == 5);
            sb.push_back(exp_v[i]);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL priority[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            if (i == 5) begin
                n_checks++;
                if (o_cnt_clear_bar !== 1'b0) begin
                    n_errors++;
                    $display("FAIL priority_abort_clear: got %b required 0", o_cnt_clear_bar);
                end
            end
            $display("priority[%0d]: cnt=%h busy=%b cyc=%0d", i, m_cnt, o_busy, o_cycles);
        end
        stop = 1'b0;
        abort = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt();
        logic [18:0] e;
        logic [18:0] got;
        logic [7:0]  c;
        preset = 8'h40;
        auto_reload = 1'b0;
        for (int i = 0; i < 15; i++) begin
            start = (i == 0) || (i == 2) || (i == 9);
            stop  = (i == 4);
            abort = (i == 13);
            case (i)
                0:                c = 8'h00;
                1:                c = 8'h40;
                2:                c = 8'h41;
                3:                c = 8'h42;
                4, 5, 6, 7, 8, 9: c = 8'h43;
                10:               c = 8'h44;
                11:               c = 8'h45;
                12:               c = 8'h46;
                13:               c = 8'h47;
                default:          c = 8'h00;
            endcase
            sb.push_back(mk(c, (i < 13), 0, 0, 8'd0));
            step();
            if (i == 0) preset = 8'h55;
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL halt[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            if (i == 5) begin
                n_checks++;
                if ({o_cnt_ent, o_cnt_enp} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL halt_enables {ent,enp}: got %b required 10", {o_cnt_ent, o_cnt_enp});
                end
            end
            if (i == 12) begin
                n_checks++;
                if (o_cnt_d !== 8'h40) begin
                    n_errors++;
                    $display("FAIL halt_preset_latched: got %h required 40", o_cnt_d);
                end
            end
            $display("halt[%0d]: cnt=%h busy=%b enp=%b", i, m_cnt, o_busy, o_cnt_enp);
        end
        start = 1'b0;
        stop = 1'b0;
        abort = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // All-9s preset in auto mode reloads every edge; also reaches saturation.
    task automatic test_all_nines();
        localparam int N = 260;
        logic [18:0] e;
        logic [18:0] got;
        int          cyc;
        preset = 8'h99;
        auto_reload = 1'b1;
        for (int i = 0; i < N + 3; i++) begin
            start = (i == 0);
            abort = (i == N + 1);
            cyc   = (i < 2) ? 0 : ((i - 1 > 255) ? 255 : i - 1);
            if (i == 0)
                e = mk(8'h00, 1, 0, 0, 8'd0);
            else if (i <= N)
                e = mk(8'h99, 1, 0, 0, cyc[7:0]);
            else if (i == N + 1)
                e = mk(8'h99, 0, 0, 0, 8'd255);
            else
                e = mk(8'h00, 0, 0, 0, 8'd255);
            sb.push_back(e);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL all_nines[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            $display("all_nines[%0d]: cnt=%h busy=%b cyc=%0d", i, m_cnt, o_busy, o_cycles);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        logic [18:0] e;
        logic [18:0] got;
        logic [22:0] ctl;
        preset = 8'h70;
        auto_reload = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            case (i)
                0:       e = mk(8'h00, 1, 0, 0, 8'd0);
                1:       e = mk(8'h70, 1, 0, 0, 8'd0);
                2:       e = mk(8'h71, 1, 0, 0, 8'd0);
                default: e = mk(8'h72, 1, 0, 0, 8'd0);
            endcase
            sb.push_back(e);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL async_run[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            $display("async_run[%0d]: cnt=%h busy=%b", i, m_cnt, o_busy);
        end
        start = 1'b0;
        // Drop reset between clock edges; outputs must react without a clock.
        #2;
        clear_bar = 1'b0;
        #1;
        ctl = {o_cnt_clear_bar, o_cnt_load_bar, o_cnt_ent, o_cnt_enp, o_cnt_d,
               o_busy, o_done, o_error, o_cycles};
        n_checks++;
        if (ctl !== {4'b1100, 8'h00, 3'b000, 8'h00}) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got %h required %h", ctl, {4'b1100, 8'h00, 3'b000, 8'h00});
        end
        $display("async_reset: outputs=%h", ctl);
        step();
        n_checks++;
        if (m_cnt !== 8'h72) begin
            n_errors++;
            $display("FAIL async_reset_counters_hold: got %h required 72", m_cnt);
        end
        clear_bar = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = (i == 0);
            e = (i == 0) ? mk(8'h72, 1, 0, 0, 8'd0) : mk(8'h70, 1, 0, 0, 8'd0);
            sb.push_back(e);
            step();
            got = obs();
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL async_restart[%0d] {cnt,busy,done,err,cyc}: got %h required %h", i, got, e);
            end
            $display("async_restart[%0d]: cnt=%h busy=%b", i, m_cnt, o_busy);
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        clear_bar   = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        abort       = 1'b0;
        auto_reload = 1'b0;
        preset      = 8'h00;

        test_reset();
        test_one_shot();
        test_bad_preset();
        test_auto_reload();
        test_priority();
        test_halt();
        test_all_nines();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
